// File: rtl/aes_out_serializer.sv
// aes_out_serializer
//   Receive-side companion to the aes core. Captures 128-bit result blocks
//   from the core's non-backpressurable o_data/o_data_valid strobe, buffers
//   them in a DEPTH-entry FIFO, and streams them out one byte at a time over
//   a valid/ready handshake.
//
// Parameters
//   DEPTH     : FIFO depth in blocks (power of 2, >= 2)
//   MSB_FIRST : 1 = bits [127:120] go out first, 0 = bits [7:0] go out first
//
// Ports
//   clk, reset_n   : clock (rising edge), asynchronous active-low reset
//   i_data         : result block from the core
//   i_data_valid   : one-cycle strobe qualifying i_data
//   i_flush        : synchronous flush of FIFO and serializer (top priority)
//   o_full         : FIFO occupancy == DEPTH (registered)
//   o_level        : FIFO occupancy, excluding the block being serialized
//   o_byte         : output byte
//   o_byte_valid   : o_byte is valid
//   i_byte_ready   : downstream accepts o_byte
//   o_overflow     : sticky "a block was dropped"        (AES_OUT_STATUS_EN)
//   o_drop_cnt     : saturating dropped-block count      (AES_OUT_STATUS_EN)
//
// Build option
//   AES_OUT_STATUS_EN : when defined, adds o_overflow / o_drop_cnt.
module aes_out_serializer #(
  parameter int DEPTH     = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [127:0]             i_data,
  input  logic                     i_data_valid,
  input  logic                     i_flush,
  output logic                     o_full,
  output logic [$clog2(DEPTH):0]   o_level,
  output logic [7:0]               o_byte,
  output logic                     o_byte_valid,
`ifdef AES_OUT_STATUS_EN
  output logic                     o_overflow,
  output logic [7:0]               o_drop_cnt,
`endif
  input  logic                     i_byte_ready
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  typedef enum logic {IDLE = 1'b0, SEND = 1'b1} state_t;

  logic [127:0]  mem [DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic [LW-1:0] level, level_nxt;
  state_t        state;
  logic [127:0]  shreg;
  logic [3:0]    idx;

  logic empty, full, xfer, pop, push;

  assign empty = (level == '0);
  assign full  = (level == LW'(DEPTH));
  assign xfer  = o_byte_valid && i_byte_ready;

  // The serializer takes a new block when idle, or when the last byte of
  // the current block is accepted (keeps bytes back-to-back).
  assign pop  = !i_flush && !empty &&
                ((state == IDLE) || (xfer && idx == 4'd15));
  // A full FIFO still accepts a block if a slot frees in the same cycle.
  assign push = !i_flush && i_data_valid && (!full || pop);

  assign o_level = level;
  assign o_byte  = MSB_FIRST ? shreg[127:120] : shreg[7:0];

  always_comb begin
    level_nxt = level;
    if (i_flush)             level_nxt = '0;
    else if (push && !pop)   level_nxt = level + LW'(1);
    else if (pop && !push)   level_nxt = level - LW'(1);
  end

  // Storage array carries no reset; validity is tracked by level/pointers.
  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= i_data;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wptr   <= '0;
      rptr   <= '0;
      level  <= '0;
      o_full <= 1'b0;
    end else begin
      if (i_flush) begin
        wptr <= '0;
        rptr <= '0;
      end else begin
        if (push) wptr <= wptr + AW'(1);
        if (pop)  rptr <= rptr + AW'(1);
      end
      level  <= level_nxt;
      o_full <= (level_nxt == LW'(DEPTH));
    end
  end

  // Serializer: the current byte always sits at the output end of shreg;
  // each accepted byte shifts the next one into place.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      shreg        <= '0;
      idx          <= '0;
      o_byte_valid <= 1'b0;
    end else if (i_flush) begin
      state        <= IDLE;
      idx          <= '0;
      o_byte_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (pop) begin
            shreg        <= mem[rptr];
            idx          <= '0;
            state        <= SEND;
            o_byte_valid <= 1'b1;
          end
        end
        SEND: begin
          if (xfer) begin
            if (idx == 4'd15) begin
              idx <= '0;
              if (pop) begin
                shreg <= mem[rptr];
              end else begin
                state        <= IDLE;
                o_byte_valid <= 1'b0;
              end
            end else begin
              idx   <= idx + 4'd1;
              shreg <= MSB_FIRST ? {shreg[119:0], 8'h00} : {8'h00, shreg[127:8]};
            end
          end
        end
        default: begin
          state        <= IDLE;
          o_byte_valid <= 1'b0;
        end
      endcase
    end
  end

`ifdef AES_OUT_STATUS_EN
  logic drop;
  assign drop = !i_flush && i_data_valid && full && !pop;

  // Flush clears the status even when it coincides with a drop.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      o_overflow <= 1'b0;
      o_drop_cnt <= '0;
    end else if (i_flush) begin
      o_overflow <= 1'b0;
      o_drop_cnt <= '0;
    end else if (drop) begin
      o_overflow <= 1'b1;
      if (o_drop_cnt != 8'hff) o_drop_cnt <= o_drop_cnt + 8'd1;
    end
  end
`endif

endmodule
